// File: rtl/conv3x3_layer_seq.sv
// Control sequencer for one 3x3 same-padded conv2d+bias+ReLU layer.
// It walks filters, pixels, taps and channels, and drives the RAM/ROM addresses and the MAC strobes.
module conv3x3_layer_seq #(
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int CHANNELS = 64,
  parameter int FILTERS  = 64,
  parameter int K        = 3,
  parameter int PAD      = 1,
  parameter int FM_AW    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [FM_AW-1:0] fm_addr,
  output logic [15:0]      kernel_row,
  output logic [15:0]      kernel_col,
  output logic [15:0]      bias_row,
  output logic             bias_load,
  output logic             mac_valid,
  output logic             mac_first,
  output logic             mac_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_f,
  output logic [7:0]       out_y,
  output logic [7:0]       out_x
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int KW = (K > 1)        ? $clog2(K)        : 1;
  localparam int XW = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;
  localparam int YW = (HEIGHT > 1)   ? $clog2(HEIGHT)   : 1;

  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [15:0]   F_LAST = 16'(FILTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_f, w_f_nxt;
  logic [YW-1:0] r_i, w_i_nxt;
  logic [XW-1:0] r_j, w_j_nxt;
  logic [KW-1:0] r_m, w_m_nxt;
  logic [KW-1:0] r_n, w_n_nxt;
  logic [CW-1:0] r_c, w_c_nxt;

  logic signed [31:0] w_i_s, w_j_s, w_m_s, w_n_s, w_c_s;
  logic signed [31:0] w_in_y, w_in_x;
  logic signed [31:0] w_m_min, w_m_max, w_n_min, w_n_max;
  logic               w_inb, w_tap_first, w_tap_last;

  // In-bounds taps form a rectangle, so first/last valid tap come from its corners.
  always_comb begin
    w_i_s   = signed'(32'(r_i));
    w_j_s   = signed'(32'(r_j));
    w_m_s   = signed'(32'(r_m));
    w_n_s   = signed'(32'(r_n));
    w_c_s   = signed'(32'(r_c));
    w_in_y  = w_i_s + w_m_s - PAD;
    w_in_x  = w_j_s + w_n_s - PAD;
    w_inb   = (w_in_y >= 0) && (w_in_y < HEIGHT) && (w_in_x >= 0) && (w_in_x < WIDTH);
    w_m_min = (w_i_s >= PAD) ? 0 : PAD - w_i_s;
    w_n_min = (w_j_s >= PAD) ? 0 : PAD - w_j_s;
    w_m_max = (w_i_s + K - 1 - PAD <= HEIGHT - 1) ? K - 1 : HEIGHT - 1 + PAD - w_i_s;
    w_n_max = (w_j_s + K - 1 - PAD <= WIDTH - 1)  ? K - 1 : WIDTH - 1 + PAD - w_j_s;
    w_tap_first = (w_m_s == w_m_min) && (w_n_s == w_n_min);
    w_tap_last  = (w_m_s == w_m_max) && (w_n_s == w_n_max);
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign bias_load  = (r_state == S_BIAS);
  assign out_valid  = (r_state == S_OUT);
  assign mac_valid  = (r_state == S_MAC) && w_inb;
  assign mac_first  = mac_valid && (r_c == '0) && w_tap_first;
  assign mac_last   = mac_valid && (r_c == C_LAST) && w_tap_last;
  assign fm_addr    = mac_valid ? FM_AW'(w_c_s * (WIDTH * HEIGHT) + w_in_y * WIDTH + w_in_x) : '0;
  assign kernel_row = 16'(w_m_s * (K * CHANNELS) + w_n_s * CHANNELS + w_c_s);
  assign kernel_col = r_f;
  assign bias_row   = r_f;
  assign out_f      = r_f;
  assign out_y      = 8'(r_i);
  assign out_x      = 8'(r_j);

  always_comb begin
    w_state_nxt = r_state;
    w_f_nxt     = r_f;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_m_nxt     = r_m;
    w_n_nxt     = r_n;
    w_c_nxt     = r_c;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_BIAS;
          w_f_nxt     = '0;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_m_nxt     = '0;
          w_n_nxt     = '0;
          w_c_nxt     = '0;
        end
      end
      S_BIAS: begin
        w_state_nxt = S_MAC;
        w_m_nxt     = '0;
        w_n_nxt     = '0;
        w_c_nxt     = '0;
      end
      S_MAC: begin
        // Padded taps that follow the last valid tap are skipped outright.
        if (mac_last) begin
          w_state_nxt = S_OUT;
          w_m_nxt     = '0;
          w_n_nxt     = '0;
          w_c_nxt     = '0;
        end else if (w_inb && (r_c != C_LAST)) begin
          w_c_nxt = r_c + 1'b1;
        end else begin
          w_c_nxt = '0;
          if (r_n == K_LAST) begin
            w_n_nxt = '0;
            w_m_nxt = r_m + 1'b1;
          end else begin
            w_n_nxt = r_n + 1'b1;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_nxt = S_MAC;
          if (r_j == X_LAST) begin
            w_j_nxt = '0;
            if (r_i == Y_LAST) begin
              w_i_nxt = '0;
              if (r_f == F_LAST) begin
                w_f_nxt     = '0;
                w_state_nxt = S_DONE;
              end else begin
                w_f_nxt     = r_f + 1'b1;
                w_state_nxt = S_BIAS;
              end
            end else begin
              w_i_nxt = r_i + 1'b1;
            end
          end else begin
            w_j_nxt = r_j + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_f     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_f     <= w_f_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_m     <= w_m_nxt;
      r_n     <= w_n_nxt;
      r_c     <= w_c_nxt;
    end
  end

endmodule

// File: tb/tb_conv3x3_layer_seq.sv
// Directed bench for conv3x3_layer_seq: default 8x8x64 config for filter 0 plus a small full-layer run.
`timescale 1ns/1ps
module tb_conv3x3_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, out_ready;
  logic        busy, done, bias_load, mac_valid, mac_first, mac_last, out_valid;
  logic [11:0] fm_addr;
  logic [15:0] kernel_row, kernel_col, bias_row, out_f;
  logic [7:0]  out_y, out_x;

  logic        s_start, s_out_ready;
  logic        s_busy, s_done, s_bias_load, s_mac_valid, s_mac_first, s_mac_last, s_out_valid;
  logic [2:0]  s_fm_addr;
  logic [15:0] s_kernel_row, s_kernel_col, s_bias_row, s_out_f;
  logic [7:0]  s_out_y, s_out_x;

  conv3x3_layer_seq dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fm_addr(fm_addr), .kernel_row(kernel_row), .kernel_col(kernel_col),
    .bias_row(bias_row), .bias_load(bias_load), .mac_valid(mac_valid),
    .mac_first(mac_first), .mac_last(mac_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_f(out_f), .out_y(out_y), .out_x(out_x)
  );

  conv3x3_layer_seq #(
    .WIDTH(2), .HEIGHT(2), .CHANNELS(2), .FILTERS(2), .K(3), .PAD(1), .FM_AW(3)
  ) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .fm_addr(s_fm_addr), .kernel_row(s_kernel_row), .kernel_col(s_kernel_col),
    .bias_row(s_bias_row), .bias_load(s_bias_load), .mac_valid(s_mac_valid),
    .mac_first(s_mac_first), .mac_last(s_mac_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_f(s_out_f), .out_y(s_out_y), .out_x(s_out_x)
  );

  typedef struct {
    int f, y, x, nvalid, ncyc, faddr, frow, laddr, lrow;
  } exp_t;

  exp_t        q[$];
  logic [31:0] sq[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-pixel tap trace for the 8x8x64, K=3, PAD=1 configuration.
  function automatic exp_t model(input int f, input int y, input int x);
    exp_t e;
    int   pads = 0;
    int   ninb = 0;
    e.f = f; e.y = y; e.x = x;
    e.faddr = 0; e.frow = 0; e.laddr = 0; e.lrow = 0; e.ncyc = 0;
    for (int m = 0; m < 3; m++) begin
      for (int n = 0; n < 3; n++) begin
        int yy = y + m - 1;
        int xx = x + n - 1;
        if (yy >= 0 && yy < 8 && xx >= 0 && xx < 8) begin
          if (ninb == 0) begin
            e.faddr = yy * 8 + xx;
            e.frow  = (m * 3 + n) * 64;
          end
          ninb++;
          e.laddr = 63 * 64 + yy * 8 + xx;
          e.lrow  = (m * 3 + n) * 64 + 63;
          e.ncyc  = ninb * 64 + pads;
        end else begin
          pads++;
        end
      end
    end
    e.nvalid = ninb * 64;
    return e;
  endfunction

  int     m_valid, m_cyc, m_first, m_last;
  longint m_faddr, m_frow, m_laddr, m_lrow;

  always @(negedge clk) begin
    if (rst) begin
      m_valid <= 0; m_cyc <= 0; m_first <= 0; m_last <= 0;
    end else begin
      if (mac_valid) begin
        m_valid <= m_valid + 1;
        if (mac_first) begin
          m_first <= m_first + 1;
          m_faddr <= 64'(fm_addr);
          m_frow  <= 64'(kernel_row);
        end
        if (mac_last) begin
          m_last  <= m_last + 1;
          m_laddr <= 64'(fm_addr);
          m_lrow  <= 64'(kernel_row);
        end
      end
      if (busy && !out_valid && !bias_load && !done) m_cyc <= m_cyc + 1;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(q.size() > 0), 1);
        if (q.size() > 0) begin
          chk("pix_f", 64'(out_f), 64'(q[0].f));
          chk("pix_y", 64'(out_y), 64'(q[0].y));
          chk("pix_x", 64'(out_x), 64'(q[0].x));
          chk("pix_nvalid", 64'(m_valid), 64'(q[0].nvalid));
          chk("pix_mac_cycles", 64'(m_cyc), 64'(q[0].ncyc));
          chk("pix_first_cnt", 64'(m_first), 1);
          chk("pix_last_cnt", 64'(m_last), 1);
          chk("pix_first_addr", m_faddr, 64'(q[0].faddr));
          chk("pix_first_krow", m_frow, 64'(q[0].frow));
          chk("pix_last_addr", m_laddr, 64'(q[0].laddr));
          chk("pix_last_krow", m_lrow, 64'(q[0].lrow));
          q.delete(0);
        end
        m_valid <= 0; m_cyc <= 0; m_first <= 0; m_last <= 0;
      end
    end
  end

  int s_nbias = 0;
  int s_ndone = 0;
  int s_nhs   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (s_bias_load) s_nbias <= s_nbias + 1;
      if (s_done)      s_ndone <= s_ndone + 1;
      if (s_out_valid && s_out_ready) begin
        s_nhs <= s_nhs + 1;
        chk("s_sb_nonempty", 64'(sq.size() > 0), 1);
        if (sq.size() > 0) begin
          chk("s_pix_fyx", 64'({s_out_f, s_out_y, s_out_x}), 64'(sq[0]));
          sq.delete(0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, done, bias_load, mac_valid, mac_first, mac_last, out_valid}), 0);
    chk({tag, "_addr"}, 64'({fm_addr, kernel_row, kernel_col, bias_row}), 0);
    chk({tag, "_pix"},  64'({out_f, out_y, out_x}), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    s_start = 1'b0; s_out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        q.push_back(model(0, y, x));
    start = 1'b1; tick(); start = 1'b0;
    chk("bias_cycle", 64'({busy, bias_load, mac_valid, bias_row}), 64'({3'b110, 16'd0}));
    tick();
    chk("bias_one_cycle", 64'(bias_load), 0);

    for (int p = 0; p < 64; p++) begin
      k = 0;
      while (!out_valid && k < 3000) begin tick(); k++; end
      chk("out_valid_wait", 64'(out_valid), 1);
      if (!out_valid) break;
      if (p == 1) begin
        for (int h = 0; h < 10; h++) begin
          chk("bp_hold", 64'({out_valid, mac_valid, out_f, out_y, out_x}),
              64'({2'b10, 16'd0, 8'd0, 8'd1}));
          tick();
        end
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      if (p == 1)
        chk("bp_release", 64'({out_valid, mac_valid, out_x}), 64'({2'b00, 8'd2}));
      if (p == 63)
        chk("next_filter_bias", 64'({bias_load, bias_row, out_f, out_y, out_x}),
            64'({1'b1, 16'd1, 16'd1, 16'd0}));
    end
    chk("sb_drained", 64'(q.size()), 0);

    k = 0;
    while (!mac_valid && k < 50) begin tick(); k++; end
    chk("mac_resume", 64'(mac_valid), 1);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    check_reset_outputs("async_reset");
    tick(); tick();
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_bias", 64'({busy, bias_load, bias_row}), 64'({2'b11, 16'd0}));
    rst = 1'b1;
    q.delete();
    tick(); tick();
    rst = 1'b0;
    tick();

    s_out_ready = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 2; x++)
          sq.push_back({16'(f), 8'(y), 8'(x)});
    s_start = 1'b1; tick(); s_start = 1'b0;
    repeat (15) tick();
    chk("s_busy_mid", 64'(s_busy), 1);
    s_start = 1'b1; tick(); s_start = 1'b0;
    k = 0;
    while (!s_done && k < 2000) begin tick(); k++; end
    chk("s_done_seen", 64'(s_done), 1);
    chk("s_busy_at_done", 64'(s_busy), 1);
    tick();
    chk("s_after_done", 64'({s_busy, s_done}), 0);
    repeat (5) tick();
    chk("s_idle_stays", 64'(s_busy), 0);
    chk("s_handshakes", 64'(s_nhs), 8);
    chk("s_bias_loads", 64'(s_nbias), 2);
    chk("s_done_pulses", 64'(s_ndone), 1);
    chk("s_sb_drained", 64'(sq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
